// File: rtl/seq_recorder_mlane.sv
`default_nettype none
// ============================================================================
// Module   : seq_recorder_mlane
// Purpose  : Multi-lane, order-preserving source-tag FIFO for the TL TX
//            fragmentation path. Up to WR_LANES tags can be pushed and up to
//            RD_LANES tags popped per cycle. Depth can be any value >= 2.
//            A write in the same cycle can use slots freed by that cycle's read.
// Revision : 1.0 - initial release
// ============================================================================
module seq_recorder_mlane #(
  parameter int                    DATA_WIDTH = 3,
  parameter int                    FIFO_DEPTH = 257,
  parameter int                    WR_LANES   = 4,
  parameter int                    RD_LANES   = 2,
  parameter logic [DATA_WIDTH-1:0] EMPTY_VAL  = '0,
  parameter int                    CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             arst,
  input  logic                             wr_en,
  input  logic [$clog2(WR_LANES+1)-1:0]    wr_count,
  input  logic [WR_LANES*DATA_WIDTH-1:0]   wr_data,
  output logic                             wr_accept,
  input  logic                             rd_en,
  input  logic [$clog2(RD_LANES+1)-1:0]    rd_count,
  output logic                             rd_accept,
  output logic [RD_LANES*DATA_WIDTH-1:0]   rd_data,
  output logic [RD_LANES-1:0]              rd_valid,
  output logic [CNT_W-1:0]                 occupancy,
  output logic [CNT_W-1:0]                 available,
  output logic                             full,
  output logic                             empty,
  output logic                             ovf_err,
  output logic                             unf_err
);

  localparam int WC_W  = $clog2(WR_LANES + 1);
  localparam int RC_W  = $clog2(RD_LANES + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Two spare bits cover ptr + lane offset and count sums without overflow.
  localparam int SUM_W = CNT_W + 2;
  localparam logic [SUM_W-1:0] C_DEPTH = SUM_W'(FIFO_DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]               wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0]               rd_ptr_q,    rd_ptr_d;
  logic [CNT_W-1:0]               occupancy_q, occupancy_d;
  logic [CNT_W-1:0]               available_q, available_d;
  logic [RD_LANES*DATA_WIDTH-1:0] rd_data_q,   rd_data_d;
  logic [RD_LANES-1:0]            rd_valid_q,  rd_valid_d;
  logic                           ovf_err_q,   ovf_err_d;
  logic                           unf_err_q,   unf_err_d;

  // --------------------------------------------------------------------------
  // Request qualification
  // --------------------------------------------------------------------------
  logic [SUM_W-1:0] w_wr_cnt_ext;
  logic [SUM_W-1:0] w_rd_cnt_ext;
  logic [SUM_W-1:0] w_occ_ext;
  logic [SUM_W-1:0] w_avail_ext;
  logic [SUM_W-1:0] w_rd_free;
  logic [SUM_W-1:0] w_wr_add;
  logic             w_wr_req;
  logic             w_rd_req;
  logic             w_wr_accept;
  logic             w_rd_accept;

  assign w_wr_cnt_ext = SUM_W'(wr_count);
  assign w_rd_cnt_ext = SUM_W'(rd_count);
  assign w_occ_ext    = SUM_W'(occupancy_q);
  assign w_avail_ext  = SUM_W'(available_q);

  assign w_wr_req = wr_en && (wr_count != '0);
  assign w_rd_req = rd_en && (rd_count != '0);

  // Reads see only start-of-cycle occupancy, so there is no write bypass.
  assign w_rd_accept = w_rd_req
                    && (w_rd_cnt_ext <= SUM_W'(RD_LANES))
                    && (w_rd_cnt_ext <= w_occ_ext);

  assign w_rd_free = w_rd_accept ? w_rd_cnt_ext : '0;

  // Writes may also consume the slots released by this cycle's read.
  assign w_wr_accept = w_wr_req
                    && (w_wr_cnt_ext <= SUM_W'(WR_LANES))
                    && (w_wr_cnt_ext <= (w_avail_ext + w_rd_free));

  assign w_wr_add = w_wr_accept ? w_wr_cnt_ext : '0;

  assign wr_accept = w_wr_accept;
  assign rd_accept = w_rd_accept;

  // --------------------------------------------------------------------------
  // Per-lane slot addresses with single-subtract wrap
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0]    w_wr_slot [WR_LANES];
  logic [PTR_W-1:0]    w_rd_slot [RD_LANES];
  logic [WR_LANES-1:0] w_wr_lane_en;
  logic [RD_LANES-1:0] w_rd_lane_en;

  for (genvar gi = 0; gi < WR_LANES; gi++) begin : g_wr_slot
    logic [SUM_W-1:0] w_sum;
    assign w_sum            = SUM_W'(wr_ptr_q) + SUM_W'(gi);
    assign w_wr_slot[gi]    = (w_sum >= C_DEPTH) ? PTR_W'(w_sum - C_DEPTH) : PTR_W'(w_sum);
    assign w_wr_lane_en[gi] = w_wr_accept && (WC_W'(gi) < wr_count);
  end

  for (genvar gi = 0; gi < RD_LANES; gi++) begin : g_rd_slot
    logic [SUM_W-1:0] w_sum;
    assign w_sum            = SUM_W'(rd_ptr_q) + SUM_W'(gi);
    assign w_rd_slot[gi]    = (w_sum >= C_DEPTH) ? PTR_W'(w_sum - C_DEPTH) : PTR_W'(w_sum);
    assign w_rd_lane_en[gi] = w_rd_accept && (RC_W'(gi) < rd_count);
  end

  // --------------------------------------------------------------------------
  // Next-state computation
  // --------------------------------------------------------------------------
  logic [SUM_W-1:0] w_wr_ptr_sum;
  logic [SUM_W-1:0] w_rd_ptr_sum;
  logic [SUM_W-1:0] w_occ_next;

  assign w_wr_ptr_sum = SUM_W'(wr_ptr_q) + w_wr_add;
  assign w_rd_ptr_sum = SUM_W'(rd_ptr_q) + w_rd_free;
  assign w_occ_next   = w_occ_ext + w_wr_add - w_rd_free;

  // Next pointers, counters, error flags and registered read lanes.
  always_comb begin
    wr_ptr_d    = (w_wr_ptr_sum >= C_DEPTH) ? PTR_W'(w_wr_ptr_sum - C_DEPTH) : PTR_W'(w_wr_ptr_sum);
    rd_ptr_d    = (w_rd_ptr_sum >= C_DEPTH) ? PTR_W'(w_rd_ptr_sum - C_DEPTH) : PTR_W'(w_rd_ptr_sum);
    occupancy_d = CNT_W'(w_occ_next);
    available_d = CNT_W'(C_DEPTH - w_occ_next);
    ovf_err_d   = ovf_err_q || (w_wr_req && !w_wr_accept);
    unf_err_d   = unf_err_q || (w_rd_req && !w_rd_accept);
    rd_valid_d  = w_rd_lane_en;
    rd_data_d   = {RD_LANES{EMPTY_VAL}};
    for (int i = 0; i < RD_LANES; i++) begin
      if (w_rd_lane_en[i]) begin
        rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[w_rd_slot[i]];
      end
    end
  end

  // Control and output registers; reset overrides any same-cycle request.
  always_ff @(posedge clk) begin
    if (arst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occupancy_q <= '0;
      available_q <= CNT_W'(FIFO_DEPTH);
      ovf_err_q   <= 1'b0;
      unf_err_q   <= 1'b0;
      rd_valid_q  <= '0;
      rd_data_q   <= {RD_LANES{EMPTY_VAL}};
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occupancy_q <= occupancy_d;
      available_q <= available_d;
      ovf_err_q   <= ovf_err_d;
      unf_err_q   <= unf_err_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Storage: read slots are cleared first so a same-slot write lands last and wins.
  always_ff @(posedge clk) begin
    if (!arst) begin
      for (int i = 0; i < RD_LANES; i++) begin
        if (w_rd_lane_en[i]) begin
          mem_q[w_rd_slot[i]] <= EMPTY_VAL;
        end
      end
      for (int i = 0; i < WR_LANES; i++) begin
        if (w_wr_lane_en[i]) begin
          mem_q[w_wr_slot[i]] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign occupancy = occupancy_q;
  assign available = available_q;
  assign ovf_err   = ovf_err_q;
  assign unf_err   = unf_err_q;
  assign full      = (occupancy_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (occupancy_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_seq_recorder_mlane.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_recorder_mlane
// Purpose  : Directed self-checking bench for seq_recorder_mlane (default
//            parameters: 3-bit tags, depth 257, 4 write / 2 read lanes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_recorder_mlane;

  logic        clk = 1'b0;
  logic        arst;
  logic        wr_en;
  logic [2:0]  wr_count;
  logic [11:0] wr_data;
  logic        wr_accept;
  logic        rd_en;
  logic [1:0]  rd_count;
  logic        rd_accept;
  logic [5:0]  rd_data;
  logic [1:0]  rd_valid;
  logic [8:0]  occupancy;
  logic [8:0]  available;
  logic        full;
  logic        empty;
  logic        ovf_err;
  logic        unf_err;

  int checks = 0;
  int errors = 0;
  int e_next = 0;

  seq_recorder_mlane dut (
    .clk       (clk),
    .arst      (arst),
    .wr_en     (wr_en),
    .wr_count  (wr_count),
    .wr_data   (wr_data),
    .wr_accept (wr_accept),
    .rd_en     (rd_en),
    .rd_count  (rd_count),
    .rd_accept (rd_accept),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .occupancy (occupancy),
    .available (available),
    .full      (full),
    .empty     (empty),
    .ovf_err   (ovf_err),
    .unf_err   (unf_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply request inputs and let combinational outputs settle.
  task automatic drive(input logic we, input logic [2:0] wc, input logic [11:0] wd,
                       input logic re, input logic [1:0] rc);
    wr_en    = we;
    wr_count = wc;
    wr_data  = wd;
    rd_en    = re;
    rd_count = rc;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 12'd0, 1'b0, 2'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write n tags numbered e_next.. (tag = low 3 bits of the running index).
  task automatic push_tags(input int n, input logic re, input logic [1:0] rc);
    logic [11:0] wd;
    int          t;
    wd = '0;
    for (int j = 0; j < n; j++) begin
      t = e_next + j;
      wd[j*3 +: 3] = t[2:0];
    end
    drive(1'b1, 3'(n), wd, re, rc);
  endtask

  initial begin
    arst = 1'b1;
    idle();
    step();
    step();

    // Reset state
    check_val("rst_occ",   32'(occupancy), 32'd0);
    check_val("rst_avail", 32'(available), 32'd257);
    check_val("rst_empty", 32'(empty),     32'd1);
    check_val("rst_full",  32'(full),      32'd0);
    check_val("rst_valid", 32'(rd_valid),  32'd0);
    check_val("rst_data",  32'(rd_data),   32'd0);
    check_val("rst_ovf",   32'(ovf_err),   32'd0);
    check_val("rst_unf",   32'(unf_err),   32'd0);
    arst = 1'b0;

    // Zero counts with enables high are no-ops
    drive(1'b1, 3'd0, 12'd0, 1'b1, 2'd0);
    check_val("zero_wacc", 32'(wr_accept), 32'd0);
    check_val("zero_racc", 32'(rd_accept), 32'd0);
    step();
    idle();
    check_val("zero_ovf", 32'(ovf_err), 32'd0);
    check_val("zero_unf", 32'(unf_err), 32'd0);

    // Basic write of {A,B,C,D} = {1,2,3,4}, then two reads of 2
    drive(1'b1, 3'd4, {3'd4, 3'd3, 3'd2, 3'd1}, 1'b0, 2'd0);
    check_val("w4_acc", 32'(wr_accept), 32'd1);
    step();
    idle();
    check_val("w4_occ",   32'(occupancy), 32'd4);
    check_val("w4_avail", 32'(available), 32'd253);
    check_val("w4_empty", 32'(empty),     32'd0);
    drive(1'b0, 3'd0, 12'd0, 1'b1, 2'd2);
    check_val("r2a_acc", 32'(rd_accept), 32'd1);
    step();
    check_val("r2a_valid", 32'(rd_valid), 32'd3);
    check_val("r2a_data",  32'(rd_data),  32'({3'd2, 3'd1}));
    step();
    idle();
    check_val("r2b_valid", 32'(rd_valid),  32'd3);
    check_val("r2b_data",  32'(rd_data),   32'({3'd4, 3'd3}));
    check_val("r2b_empty", 32'(empty),     32'd1);
    check_val("r2b_occ",   32'(occupancy), 32'd0);
    step();
    check_val("idle_valid", 32'(rd_valid), 32'd0);
    check_val("idle_data",  32'(rd_data),  32'd0);

    // Fill to exactly full: 64 writes of 4, then 1
    e_next = 0;
    for (int k = 0; k < 64; k++) begin
      push_tags(4, 1'b0, 2'd0);
      step();
      e_next += 4;
    end
    push_tags(1, 1'b0, 2'd0);
    step();
    e_next += 1;
    idle();
    check_val("fill_full",  32'(full),      32'd1);
    check_val("fill_occ",   32'(occupancy), 32'd257);
    check_val("fill_avail", 32'(available), 32'd0);
    check_val("fill_ovf",   32'(ovf_err),   32'd0);

    // Full: read 2 and write 2 in the same cycle
    push_tags(2, 1'b1, 2'd2);
    check_val("frw_racc", 32'(rd_accept), 32'd1);
    check_val("frw_wacc", 32'(wr_accept), 32'd1);
    step();
    e_next += 2;
    idle();
    check_val("frw_data",  32'(rd_data),   32'({3'd1, 3'd0}));
    check_val("frw_valid", 32'(rd_valid),  32'd3);
    check_val("frw_occ",   32'(occupancy), 32'd257);
    check_val("frw_full",  32'(full),      32'd1);
    check_val("frw_ovf",   32'(ovf_err),   32'd0);

    // Drain 3 to reach 254 entries
    drive(1'b0, 3'd0, 12'd0, 1'b1, 2'd2);
    step();
    check_val("d2_data", 32'(rd_data), 32'({3'd3, 3'd2}));
    drive(1'b0, 3'd0, 12'd0, 1'b1, 2'd1);
    step();
    idle();
    check_val("d1_data",  32'(rd_data),   32'({3'd0, 3'd4}));
    check_val("d1_valid", 32'(rd_valid),  32'd1);
    check_val("d1_occ",   32'(occupancy), 32'd254);

    // Overflow: write 4 into 3 free slots, then write 3
    push_tags(4, 1'b0, 2'd0);
    check_val("ovf_wacc", 32'(wr_accept), 32'd0);
    step();
    idle();
    check_val("ovf_flag", 32'(ovf_err),   32'd1);
    check_val("ovf_occ",  32'(occupancy), 32'd254);
    push_tags(3, 1'b0, 2'd0);
    check_val("w3_wacc", 32'(wr_accept), 32'd1);
    step();
    idle();
    check_val("w3_full", 32'(full),      32'd1);
    check_val("w3_occ",  32'(occupancy), 32'd257);

    // Wrap-around: reset, move wr_ptr to 255 and rd_ptr to 255
    arst = 1'b1;
    step();
    arst = 1'b0;
    check_val("rst2_ovf", 32'(ovf_err), 32'd0);
    e_next = 0;
    for (int c = 0; c < 85; c++) begin
      push_tags(3, (c > 0), (c > 0) ? 2'd2 : 2'd0);
      step();
      e_next += 3;
    end
    idle();
    check_val("wrap_occ", 32'(occupancy), 32'd87);
    for (int c = 0; c < 43; c++) begin
      drive(1'b0, 3'd0, 12'd0, 1'b1, 2'd2);
      step();
    end
    drive(1'b0, 3'd0, 12'd0, 1'b1, 2'd1);
    step();
    idle();
    check_val("wrap_empty", 32'(empty), 32'd1);
    check_val("wrap_unf",   32'(unf_err), 32'd0);
    drive(1'b1, 3'd4, {3'd6, 3'd5, 3'd7, 3'd1}, 1'b0, 2'd0);
    check_val("wrap_wacc", 32'(wr_accept), 32'd1);
    step();
    drive(1'b0, 3'd0, 12'd0, 1'b1, 2'd2);
    step();
    check_val("wrap_r1", 32'(rd_data), 32'({3'd7, 3'd1}));
    drive(1'b0, 3'd0, 12'd0, 1'b1, 2'd2);
    step();
    idle();
    check_val("wrap_r2",    32'(rd_data), 32'({3'd6, 3'd5}));
    check_val("wrap_empty2", 32'(empty),  32'd1);
    drive(1'b1, 3'd1, 12'd2, 1'b0, 2'd0);
    step();
    drive(1'b0, 3'd0, 12'd0, 1'b1, 2'd1);
    step();
    idle();
    check_val("wrap_r3", 32'(rd_data), 32'({3'd0, 3'd2}));

    // Empty FIFO, write 1 and read 1 together: read rejected
    drive(1'b1, 3'd1, 12'd5, 1'b1, 2'd1);
    check_val("unf_racc", 32'(rd_accept), 32'd0);
    check_val("unf_wacc", 32'(wr_accept), 32'd1);
    step();
    idle();
    check_val("unf_flag",  32'(unf_err),   32'd1);
    check_val("unf_valid", 32'(rd_valid),  32'd0);
    check_val("unf_occ",   32'(occupancy), 32'd1);
    drive(1'b0, 3'd0, 12'd0, 1'b1, 2'd1);
    step();
    idle();
    check_val("unf_rvalid", 32'(rd_valid),  32'd1);
    check_val("unf_rdata",  32'(rd_data),   32'({3'd0, 3'd5}));
    check_val("unf_rocc",   32'(occupancy), 32'd0);

    // Oversized write count is rejected
    drive(1'b1, 3'd5, 12'hFFF, 1'b0, 2'd0);
    check_val("big_wacc", 32'(wr_accept), 32'd0);
    step();
    idle();
    check_val("big_ovf", 32'(ovf_err),   32'd1);
    check_val("big_occ", 32'(occupancy), 32'd0);

    // Reset during an accepted read
    drive(1'b1, 3'd2, {6'd0, 3'd3, 3'd2}, 1'b0, 2'd0);
    step();
    drive(1'b0, 3'd0, 12'd0, 1'b1, 2'd2);
    arst = 1'b1;
    check_val("rr_racc", 32'(rd_accept), 32'd1);
    step();
    arst = 1'b0;
    idle();
    check_val("rr_valid", 32'(rd_valid),  32'd0);
    check_val("rr_data",  32'(rd_data),   32'd0);
    check_val("rr_occ",   32'(occupancy), 32'd0);
    check_val("rr_avail", 32'(available), 32'd257);
    check_val("rr_ovf",   32'(ovf_err),   32'd0);
    check_val("rr_unf",   32'(unf_err),   32'd0);
    check_val("rr_empty", 32'(empty),     32'd1);
    step();
    check_val("rr_valid2", 32'(rd_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_recorder_mlane.md
Name: seq_recorder_mlane

Overview:
Parametrised multi-lane sequence recorder FIFO for the TL TX data-fragmentation path. Each cycle the Tx arbiter pushes 0..WR_LANES source tags and the fragmentation logic pops 0..RD_LANES tags, preserving grant order. Depth need not be a power of two. Occupancy and free-space counters are exact. A read and a write in the same cycle are fully resolved, including a write into slots freed by that cycle's read.

Parameters:
DATA_WIDTH, 3, width of one source tag (Tx_Arbiter_Sources_t encoding)
FIFO_DEPTH, 257, number of entries; any value >= 2
WR_LANES, 4, maximum tags written per cycle (1..8)
RD_LANES, 2, maximum tags read per cycle (1..8)
EMPTY_VAL, 0, tag value (NO_SOURCE) for invalid read lanes and cleared slots
CNT_W, $clog2(FIFO_DEPTH+1), width of the count outputs

Ports:
clk  in  1  clock
arst  in  1  reset, synchronous, active-high
wr_en  in  1  write request
wr_count  in  $clog2(WR_LANES+1)  tags to write; lane 0 is oldest
wr_data  in  WR_LANES*DATA_WIDTH  lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
wr_accept  out  1  combinational; the write this cycle is committed
rd_en  in  1  read request
rd_count  in  $clog2(RD_LANES+1)  tags to read
rd_accept  out  1  combinational; the read this cycle is committed
rd_data  out  RD_LANES*DATA_WIDTH  registered read tags; lane 0 is oldest
rd_valid  out  RD_LANES  registered per-lane valid mask
occupancy  out  CNT_W  registered count of stored tags
available  out  CNT_W  registered FIFO_DEPTH - occupancy
full  out  1  occupancy == FIFO_DEPTH
empty  out  1  occupancy == 0
ovf_err  out  1  sticky; a write was rejected
unf_err  out  1  sticky; a read was rejected

Behaviour:
- Reset (arst high at a clk edge):
  - Pointers are cleared to 0.
  - occupancy = 0, available = FIFO_DEPTH, empty = 1, full = 0.
  - rd_data = all lanes EMPTY_VAL, rd_valid = 0, ovf_err = 0, unf_err = 0.
  - Stored contents are don't-care.
  - Reset takes priority over any same-cycle request. An in-flight read produces no rd_valid on the following cycle.
- Pointers run modulo FIFO_DEPTH with per-lane wrap: slot = (ptr + i) >= FIFO_DEPTH ? ptr + i - FIFO_DEPTH : ptr + i. No modulo operator or power-of-two assumption is allowed.
- Read evaluation uses start-of-cycle occupancy only.
  - rd_accept = rd_en && rd_count != 0 && rd_count <= RD_LANES && rd_count <= occupancy.
- Write may use slots freed by an accepted read in the same cycle.
  - rd_free = rd_accept ? rd_count : 0.
  - wr_accept = wr_en && wr_count != 0 && wr_count <= WR_LANES && wr_count <= available + rd_free.
  - A full FIFO with a simultaneous read of k tags and a write of at most k tags therefore succeeds.
- No write-to-read bypass. An empty FIFO with a simultaneous write and read rejects the read. The written tags become readable on the next cycle.
- Requests are all-or-nothing: a request is either committed for its full count or rejected entirely. There are no partial writes or reads.
- Rejection errors:
  - ovf_err sets when wr_en && wr_count != 0 && !wr_accept.
  - unf_err sets when rd_en && rd_count != 0 && !rd_accept.
  - Both flags clear only on reset.
- A count of 0 with its enable high is a no-op. It is not an error.
- Write commit: lanes 0..wr_count-1 go to slots wr_ptr+0..wr_count-1 (wrapped). Then wr_ptr advances by wr_count (wrapped).
- Read commit, one-cycle latency:
  - On the next edge, rd_data lanes 0..rd_count-1 take the tags at rd_ptr+0..rd_count-1, and rd_valid[i] = (i < rd_count).
  - Lanes >= rd_count get EMPTY_VAL.
  - The read slots are overwritten with EMPTY_VAL unless the same cycle's write targets the same slot; the write wins.
  - rd_ptr then advances by rd_count.
- Cycles with no accepted read: rd_valid = 0 and rd_data = all EMPTY_VAL.
- Counters update on the edge: occupancy_next = occupancy + (wr_accept ? wr_count : 0) - rd_free. available is kept consistent with occupancy every cycle.
- full and empty are decoded from the registered occupancy.
- Invariant: occupancy + available == FIFO_DEPTH at all times.

Test Plan:
- Reset, then write 4 tags {A,B,C,D} -> wr_accept=1. Next cycle occupancy=4, available=253. Reads of 2 then 2 return {A,B} then {C,D} with rd_valid=2'b11 at 1-cycle latency. After that, empty=1.
- Fill to FIFO_DEPTH-3 entries, write 4 -> wr_accept=0, ovf_err=1, occupancy unchanged. Then write 3 -> accepted, full=1.
- With full=1, read 2 and write 2 in the same cycle -> both accepted, occupancy stays 257. Oldest 2 tags appear on rd_data. ovf_err stays 0.
- Wrap-around: place wr_ptr = 255 and write 4 -> slots 255, 256, 0, 1 are written. Subsequent reads return the tags in order across the wrap. wr_ptr ends at 2.
- Empty FIFO with wr_count=1 and rd_count=1 in the same cycle -> rd_accept=0, unf_err=1. Next cycle a read of 1 returns the tag with rd_valid=2'b01 and rd_data lane1=EMPTY_VAL.
- Assert arst while a read of 2 is accepted -> next cycle rd_valid=0, occupancy=0, available=257, both error flags cleared.
